// File: rtl/accum_unit_pkg.sv
// accum_unit_pkg
// Shared definitions for the streaming accumulator: the two-state FSM
// encoding used by accum_unit.
package accum_unit_pkg;

  // ST_ACC: absorbing operand beats. ST_OUT: holding the frame result.
  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

endpackage : accum_unit_pkg

// File: rtl/accum_unit_ripple_carry.sv
// ripple_carry
// Purely combinational WIDTH-bit ripple-carry adder.
// Ports:
//   Number1_i, Number2_i : addends
//   Carry_i              : carry into bit 0
//   Result_o             : sum modulo 2^WIDTH
//   Carry_o              : carry out of the top bit
module ripple_carry #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] Number1_i,
  input  logic [WIDTH-1:0] Number2_i,
  input  logic             Carry_i,
  output logic [WIDTH-1:0] Result_o,
  output logic             Carry_o
);

  // The carry is a block-local variable updated bit by bit, so the chain is
  // expressed as one sequential walk instead of a self-referencing vector.
  always_comb begin : ripple
    logic carry;
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value unassigned and infers a latch.
    Result_o = '0;
    carry    = Carry_i;
    for (int i = 0; i < WIDTH; i++) begin
      Result_o[i] = Number1_i[i] ^ Number2_i[i] ^ carry;
      carry       = (Number1_i[i] & Number2_i[i]) |
                    (carry & (Number1_i[i] ^ Number2_i[i]));
    end
    Carry_o = carry;
  end

endmodule : ripple_carry

// File: rtl/accum_unit.sv
// accum_unit
// Streaming accumulator around a ripple-carry adder. Operand beats arriving on
// a valid/ready handshake are summed into a running register; carry-outs are
// counted (saturating). After the Last_i beat the sum and carry count are held
// on a result handshake until the consumer takes them.
// Ports:
//   Clk_i, Rst_i           : clock, async active-high reset
//   Operand_i/Valid_i/Last_i, Ready_o       : operand stream
//   Result_o/CarryCount_o/ResultValid_o, ResultReady_i : result handshake
module accum_unit
  import accum_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  input  logic [WIDTH-1:0]     Operand_i,
  input  logic                 Valid_i,
  input  logic                 Last_i,
  output logic                 Ready_o,
  output logic [WIDTH-1:0]     Result_o,
  output logic [CNT_WIDTH-1:0] CarryCount_o,
  output logic                 ResultValid_o,
  input  logic                 ResultReady_i
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q,   acc_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic [WIDTH-1:0]     sum;
  logic                 sum_carry;

  // The adder always sees the live accumulator; its output is only used when
  // a beat is actually accepted.
  ripple_carry #(
    .WIDTH (WIDTH)
  ) u_adder (
    .Number1_i (acc_q),
    .Number2_i (Operand_i),
    .Carry_i   (1'b0),
    .Result_o  (sum),
    .Carry_o   (sum_carry)
  );

  // State register
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples the pre-edge values and simulation matches the hardware.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ACC: begin
        // Ready_o is high throughout ST_ACC, so Valid_i alone qualifies a beat.
        if (Valid_i) begin
          acc_d = sum;
          // Saturate: once all ones, further carries are dropped.
          if (sum_carry && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          if (Last_i) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        // Clearing here means the next frame's first beat adds to zero.
        if (ResultReady_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // Output logic: handshake flags depend on state only.
  always_comb begin
    Ready_o       = (state_q == ST_ACC);
    ResultValid_o = (state_q == ST_OUT);
  end

  // Results come straight from the registers, so they clear with reset and
  // stay stable while the result is held.
  assign Result_o     = acc_q;
  assign CarryCount_o = cnt_q;

endmodule : accum_unit
